// File: rtl/sad_pkg.sv
// Shared defaults, FSM state type and SAD width helper for the SAD engine.
package sad_pkg;

  function automatic int sad_width(input int npix, input int width);
    return $clog2(npix * ((1 << width) - 1) + 1);
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NPIX  = 80;
  localparam int DEF_LANES = 8;
  localparam int DEF_IDX_W = 8;
  localparam int DEF_SAD_W = sad_width(DEF_NPIX, DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sad_lane_sum.sv
// Combinational sum of LANES absolute pixel differences.
module sad_lane_sum #(
  parameter int WIDTH = 8,
  parameter int LANES = 8
) (
  input  logic [LANES*WIDTH-1:0]         a,
  input  logic [LANES*WIDTH-1:0]         b,
  output logic [WIDTH+$clog2(LANES)-1:0] sum
);

  localparam int SUM_W = WIDTH + $clog2(LANES);

  logic [WIDTH:0]   diff [LANES];
  logic [WIDTH-1:0] mag  [LANES];

  // One extra bit keeps the sign of the difference, so |a-b| never wraps.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign diff[k] = {1'b0, a[k*WIDTH +: WIDTH]} - {1'b0, b[k*WIDTH +: WIDTH]};
    assign mag[k]  = diff[k][WIDTH] ? WIDTH'(-diff[k]) : diff[k][WIDTH-1:0];
  end

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = sum + SUM_W'(mag[k]);
    end
  end

endmodule

// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: reduces an 80-pixel block pair LANES
// pixels per cycle and tracks the best candidate across a search.
module sad_engine
  import sad_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NPIX  = DEF_NPIX,
  parameter int LANES = DEF_LANES,
  parameter int SAD_W = DEF_SAD_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPIX*WIDTH-1:0] cur_in,
  input  logic [NPIX*WIDTH-1:0] ref_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SAD_W-1:0]      sad_out,
  output logic                  sad_valid,
  input  logic                  out_ready,
  input  logic                  min_clear,
  output logic [SAD_W-1:0]      best_sad,
  output logic [IDX_W-1:0]      best_idx,
  output logic [IDX_W-1:0]      cand_idx
);

  localparam int STEPS     = NPIX / LANES;
  localparam int CNT_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LANE_BITS = LANES * WIDTH;
  localparam int PART_W    = WIDTH + $clog2(LANES);

  state_t state, state_nxt;

  logic [LANE_BITS-1:0] cur_q [STEPS];
  logic [LANE_BITS-1:0] ref_q [STEPS];
  logic [SAD_W-1:0]     acc;
  logic [SAD_W-1:0]     sad_total;
  logic [CNT_W-1:0]     lane_cnt;
  logic [PART_W-1:0]    partial;
  logic                 accept;
  logic                 last_lane;
  logic                 complete;

  assign in_ready  = (state == IDLE);
  assign accept    = in_ready && in_valid;
  assign last_lane = (lane_cnt == CNT_W'(STEPS - 1));
  assign complete  = (state == RUN) && last_lane;
  assign sad_total = acc + SAD_W'(partial);

  sad_lane_sum #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_sum (
    .a   (cur_q[lane_cnt]),
    .b   (ref_q[lane_cnt]),
    .sum (partial)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_lane) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the block buffers carry no reset; they are only read in RUN, which
  // is reachable solely through a capture that overwrites every slice.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int s = 0; s < STEPS; s++) begin
        cur_q[s] <= cur_in[s*LANE_BITS +: LANE_BITS];
        ref_q[s] <= ref_in[s*LANE_BITS +: LANE_BITS];
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      lane_cnt  <= '0;
      sad_out   <= '0;
      sad_valid <= 1'b0;
    end else begin
      if (accept) begin
        acc      <= '0;
        lane_cnt <= '0;
      end else if (state == RUN) begin
        acc      <= sad_total;
        lane_cnt <= last_lane ? '0 : lane_cnt + CNT_W'(1);
        if (last_lane) begin
          sad_out   <= sad_total;
          sad_valid <= 1'b1;
        end
      end else if (state == DONE && out_ready) begin
        sad_valid <= 1'b0;
      end
    end
  end

  // Clear beats completion; a candidate completing on the clear edge
  // becomes index 0 of the new search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sad <= '1;
      best_idx <= '0;
      cand_idx <= '0;
    end else if (min_clear) begin
      best_sad <= complete ? sad_total : '1;
      best_idx <= '0;
      cand_idx <= complete ? IDX_W'(1) : '0;
    end else if (complete) begin
      if (sad_total < best_sad) begin
        best_sad <= sad_total;
        best_idx <= cand_idx;
      end
      cand_idx <= cand_idx + IDX_W'(1);
    end
  end

endmodule
